slot_rr_arbiter: RTL

- Round-robin time-slot arbiter that shares one counter/datapath resource among NREQ requesters.
- A modulo-NREQ pointer selects the next requester to serve, and a dwell counter bounds each grant to DWELL cycles.
- Sits between requester logic and the shared resource. It drives a registered one-hot grant, the granted index, and a wrap pulse once per full rotation.

---
 rtl/slot_rr_arbiter_if.sv | 24 ++
 rtl/slot_rr_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/slot_rr_arbiter_if.sv
// rtl/slot_rr_arbiter_if.sv - requester/arbiter handshake bundle for the slot arbiter
interface slot_rr_arbiter_if #(
  parameter int NREQ = 5,
  parameter int IDW  = 3
);
  logic            enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_valid;
  logic            wrap;

  // requester side drives requests, arbiter side drives grants
  modport master (
    output enable, req, done,
    input  grant, grant_id, grant_valid, wrap
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_id, grant_valid, wrap
  );
endinterface

// File: rtl/slot_rr_arbiter.sv
// rtl/slot_rr_arbiter.sv - round-robin time-slot arbiter with bounded dwell per grant
module slot_rr_arbiter #(
  parameter int NREQ  = 5,
  parameter int DWELL = 4,
  parameter int IDW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  slot_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [7:0]      dwell_q, dwell_d;
  logic            wrap_q, wrap_d;

  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic            release_now;

  // first requesting index at or after ptr, wrapping by explicit compare against NREQ
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(cand);
      end
    end
  end

  // current holder gives up the slot on done, dropped request or dwell expiry
  assign release_now = bus.done[grant_id_q] | ~bus.req[grant_id_q] |
                       (dwell_q == 8'(DWELL - 1));

  // next-state and registered-output decisions
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    dwell_d    = dwell_q;
    wrap_d     = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (bus.enable && sel_found) begin
          grant_d[sel_idx] = 1'b1;
          grant_id_d       = sel_idx;
          dwell_d          = '0;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        dwell_d = dwell_q + 8'd1;
        if (release_now) begin
          grant_d = '0;
          ptr_d   = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
          wrap_d  = (grant_id_q == IDW'(NREQ - 1));
          state_d = GAP;
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      dwell_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      dwell_q    <= dwell_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = |grant_q;
  assign bus.wrap        = wrap_q;

endmodule
